// File: rtl/alu_arbiter_pkg.sv
// Shared constants, FSM state encoding and ALU op codes for the two-requester ALU arbiter.
package alu_arbiter_pkg;

  localparam int unsigned DATA_INDEX_LIMIT     = 31;
  localparam int unsigned ALU_OPRN_INDEX_LIMIT = 5;
  localparam int unsigned ALU_OPRN_W           = ALU_OPRN_INDEX_LIMIT + 1;

  // Legal operation code window; anything outside is answered with an error response.
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_MIN = 6'h01;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_MAX = 6'h09;

  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_ADD = 6'h01;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_SUB = 6'h02;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_MUL = 6'h03;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_SHR = 6'h04;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_SHL = 6'h05;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_AND = 6'h06;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_OR  = 6'h07;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_NOR = 6'h08;
  localparam logic [ALU_OPRN_W-1:0] ALU_OPRN_SLT = 6'h09;

  typedef enum logic [1:0] {
    ALU_ARB_IDLE = 2'd0,
    ALU_ARB_EXEC = 2'd1,
    ALU_ARB_RESP = 2'd2
  } alu_arb_state_t;

  // Response side-band carried alongside RSP_DATA.
  typedef struct packed {
    logic id;
    logic zero;
    logic err;
  } rsp_meta_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared single-cycle combinational ALU; OUT is zero for unknown codes, ZERO flags OUT == 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_INDEX_LIMIT + 1,
  parameter int unsigned OPRN_WIDTH = ALU_OPRN_INDEX_LIMIT + 1
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [OPRN_WIDTH-1:0] oprn,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  zero
);

  always_comb begin
    out = '0;
    case (oprn)
      OPRN_WIDTH'(ALU_OPRN_ADD): out = op1 + op2;
      OPRN_WIDTH'(ALU_OPRN_SUB): out = op1 - op2;
      OPRN_WIDTH'(ALU_OPRN_MUL): out = op1 * op2;
      OPRN_WIDTH'(ALU_OPRN_SHR): out = op1 >> op2;
      OPRN_WIDTH'(ALU_OPRN_SHL): out = op1 << op2;
      OPRN_WIDTH'(ALU_OPRN_AND): out = op1 & op2;
      OPRN_WIDTH'(ALU_OPRN_OR):  out = op1 | op2;
      OPRN_WIDTH'(ALU_OPRN_NOR): out = ~(op1 | op2);
      OPRN_WIDTH'(ALU_OPRN_SLT): out = DATA_WIDTH'($signed(op1) < $signed(op2));
      default:                   out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter_pick.sv
// Grant picker: turns the valid pair into a one-hot grant.
// With ALU_ARB_RR_EN defined a contended grant goes to the requester not accepted last.
module alu_arbiter_pick (
`ifdef ALU_ARB_RR_EN
  input  logic       ptr,
`endif
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
      grant = ptr ? 2'b01 : 2'b10;
`else
      grant = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: accept in IDLE, compute in EXEC, hold response in RESP.
// Define ALU_ARB_RR_EN for round-robin arbitration; default build is fixed priority (requester 0).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_INDEX_LIMIT + 1,
  parameter int unsigned OPRN_WIDTH = ALU_OPRN_INDEX_LIMIT + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  input  logic                  REQ1_VALID,
  output logic                  REQ0_READY,
  output logic                  REQ1_READY,
  input  logic [DATA_WIDTH-1:0] REQ0_OP1,
  input  logic [DATA_WIDTH-1:0] REQ0_OP2,
  input  logic [DATA_WIDTH-1:0] REQ1_OP1,
  input  logic [DATA_WIDTH-1:0] REQ1_OP2,
  input  logic [OPRN_WIDTH-1:0] REQ0_OPRN,
  input  logic [OPRN_WIDTH-1:0] REQ1_OPRN,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_ID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_ZERO,
  output logic                  RSP_ERR,
  output logic                  BUSY
);

  alu_arb_state_t        state_q;
  alu_arb_state_t        state_nxt;
  logic [1:0]            req_valid;
  logic [1:0]            grant;
  logic [1:0]            ready_c;
  logic                  accept_c;
  logic                  accept_id_c;
  logic                  load_rsp_c;
  logic                  oprn_legal_c;
  logic [DATA_WIDTH-1:0] op1_q;
  logic [DATA_WIDTH-1:0] op2_q;
  logic [OPRN_WIDTH-1:0] oprn_q;
  logic                  id_q;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_zero;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  rsp_meta_t             rsp_meta_q;
  logic                  rsp_valid_q;
  logic                  busy_q;

  assign req_valid = {REQ1_VALID, REQ0_VALID};

`ifdef ALU_ARB_RR_EN
  // Last accepted requester; resets to 1 so requester 0 wins the first contention.
  logic last_id_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      last_id_q <= 1'b1;
    end else if (accept_c) begin
      last_id_q <= accept_id_c;
    end
  end

  alu_arbiter_pick u_pick (
    .ptr   (last_id_q),
    .valid (req_valid),
    .grant (grant)
  );
`else
  alu_arbiter_pick u_pick (
    .valid (req_valid),
    .grant (grant)
  );
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ALU_ARB_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ALU_ARB_IDLE: if (accept_c)  state_nxt = ALU_ARB_EXEC;
      ALU_ARB_EXEC:                state_nxt = ALU_ARB_RESP;
      ALU_ARB_RESP: if (RSP_READY) state_nxt = ALU_ARB_IDLE;
      default:                     state_nxt = ALU_ARB_IDLE;
    endcase
  end

  // Output decode: READY only in IDLE, masked by the live VALID so a dropped request is not taken.
  always_comb begin
    ready_c     = 2'b00;
    accept_c    = 1'b0;
    accept_id_c = 1'b0;
    load_rsp_c  = 1'b0;
    case (state_q)
      ALU_ARB_IDLE: begin
        ready_c     = grant & req_valid;
        accept_c    = |ready_c;
        accept_id_c = ready_c[1];
      end
      ALU_ARB_EXEC: load_rsp_c = 1'b1;
      default: ;
    endcase
  end

  // Operand capture on accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op1_q  <= '0;
      op2_q  <= '0;
      oprn_q <= '0;
      id_q   <= 1'b0;
    end else if (accept_c) begin
      op1_q  <= accept_id_c ? REQ1_OP1  : REQ0_OP1;
      op2_q  <= accept_id_c ? REQ1_OP2  : REQ0_OP2;
      oprn_q <= accept_id_c ? REQ1_OPRN : REQ0_OPRN;
      id_q   <= accept_id_c;
    end
  end

  alu_arbiter_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .OPRN_WIDTH (OPRN_WIDTH)
  ) u_alu (
    .op1  (op1_q),
    .op2  (op2_q),
    .oprn (oprn_q),
    .out  (alu_out),
    .zero (alu_zero)
  );

  assign oprn_legal_c = (oprn_q >= OPRN_WIDTH'(ALU_OPRN_MIN)) &&
                        (oprn_q <= OPRN_WIDTH'(ALU_OPRN_MAX));

  // Response capture at the end of EXEC; illegal codes force a zero/error result.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_data_q <= '0;
      rsp_meta_q <= '0;
    end else if (load_rsp_c) begin
      rsp_meta_q.id <= id_q;
      if (oprn_legal_c) begin
        rsp_data_q      <= alu_out;
        rsp_meta_q.zero <= alu_zero;
        rsp_meta_q.err  <= 1'b0;
      end else begin
        rsp_data_q      <= '0;
        rsp_meta_q.zero <= 1'b1;
        rsp_meta_q.err  <= 1'b1;
      end
    end
  end

  // Status flags registered from the next state so they track the state register exactly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= (state_nxt == ALU_ARB_RESP);
      busy_q      <= (state_nxt != ALU_ARB_IDLE);
    end
  end

  assign REQ0_READY = ready_c[0];
  assign REQ1_READY = ready_c[1];
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ID     = rsp_meta_q.id;
  assign RSP_DATA   = rsp_data_q;
  assign RSP_ZERO   = rsp_meta_q.zero;
  assign RSP_ERR    = rsp_meta_q.err;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter; expected ID order follows ALU_ARB_RR_EN.
module tb_alu_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic          REQ0_READY, REQ1_READY;
  logic [DW-1:0] REQ0_OP1 = '0, REQ0_OP2 = '0, REQ1_OP1 = '0, REQ1_OP2 = '0;
  logic [OW-1:0] REQ0_OPRN = '0, REQ1_OPRN = '0;
  logic          RSP_VALID, RSP_ID, RSP_ZERO, RSP_ERR, BUSY;
  logic          RSP_READY = 1'b1;
  logic [DW-1:0] RSP_DATA;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic          zero;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .OPRN_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
    .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
    .REQ0_OP1(REQ0_OP1), .REQ0_OP2(REQ0_OP2),
    .REQ1_OP1(REQ1_OP1), .REQ1_OP2(REQ1_OP2),
    .REQ0_OPRN(REQ0_OPRN), .REQ1_OPRN(REQ1_OPRN),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [DW-1:0] data, input logic zero, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.zero = zero; e.err = err;
    sb.push_back(e);
  endtask

  task automatic set_req(input logic req, input logic v, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [OW-1:0] op);
    if (req) begin
      REQ1_VALID = v; REQ1_OP1 = a; REQ1_OP2 = b; REQ1_OPRN = op;
    end else begin
      REQ0_VALID = v; REQ0_OP1 = a; REQ0_OP2 = b; REQ0_OPRN = op;
    end
  endtask

  // Bounded wait for RSP_VALID, counting falling edges.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (RSP_VALID !== 1'b1 && edges < 12) begin
      @(negedge CLK);
      edges++;
    end
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    check({tag, "_valid"}, 64'(RSP_VALID), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_id"},   64'(RSP_ID),   64'(e.id));
      check({tag, "_data"}, 64'(RSP_DATA), 64'(e.data));
      check({tag, "_zero"}, 64'(RSP_ZERO), 64'(e.zero));
      check({tag, "_err"},  64'(RSP_ERR),  64'(e.err));
    end
  endtask

  // Single request from an idle arbiter; returns at the falling edge where RSP_VALID is seen.
  task automatic do_op(input string tag, input logic req, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [OW-1:0] op, input logic [DW-1:0] d,
                       input logic z, input logic er);
    int edges;
    set_req(req, 1'b1, a, b, op);
    push(req, d, z, er);
    #1;
    check({tag, "_ready0"}, 64'(REQ0_READY), 64'(!req));
    check({tag, "_ready1"}, 64'(REQ1_READY), 64'(req));
    @(negedge CLK);
    set_req(req, 1'b0, '0, '0, '0);
    check({tag, "_busy_exec"}, 64'(BUSY), 64'd1);
    check({tag, "_valid_exec"}, 64'(RSP_VALID), 64'd0);
    wait_rsp(edges);
    check({tag, "_latency"}, 64'(edges + 1), 64'd2);
    check_rsp(tag);
  endtask

  task automatic expect_idle(input string tag);
    @(negedge CLK);
    check({tag, "_idle_valid"}, 64'(RSP_VALID), 64'd0);
    check({tag, "_idle_busy"},  64'(BUSY), 64'd0);
  endtask

  initial begin
    int   edges;
    logic exp_id;

    // Reset values
    #2;
    check("rst_valid", 64'(RSP_VALID), 64'd0);
    check("rst_id",    64'(RSP_ID),    64'd0);
    check("rst_data",  64'(RSP_DATA),  64'd0);
    check("rst_zero",  64'(RSP_ZERO),  64'd0);
    check("rst_err",   64'(RSP_ERR),   64'd0);
    check("rst_busy",  64'(BUSY),      64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Basic add from requester 0
    do_op("add0", 1'b0, 32'd5, 32'd3, 6'h01, 32'd8, 1'b0, 1'b0);
    expect_idle("add0");

    // Illegal op code
    do_op("ill0", 1'b0, 32'd1, 32'd2, 6'h0C, 32'd0, 1'b1, 1'b1);
    expect_idle("ill0");

    // Response back-pressure: hold RESP for 5 cycles with both requesters pending
    RSP_READY = 1'b0;
    do_op("hold", 1'b0, 32'd10, 32'd20, 6'h01, 32'd30, 1'b0, 1'b0);
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_valid",  64'(RSP_VALID),  64'd1);
      check("hold_data",   64'(RSP_DATA),   64'd30);
      check("hold_ready0", 64'(REQ0_READY), 64'd0);
      check("hold_ready1", 64'(REQ1_READY), 64'd0);
      check("hold_busy",   64'(BUSY),       64'd1);
      @(negedge CLK);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    RSP_READY  = 1'b1;
    expect_idle("hold");

    // Subtract to zero from requester 1 (leaves requester 1 as last accepted)
    do_op("sub1", 1'b1, 32'd7, 32'd7, 6'h02, 32'd0, 1'b1, 1'b0);
    expect_idle("sub1");

    // Contention: both valid for four operations
    set_req(1'b0, 1'b1, 32'hF0, 32'h3C, 6'h06);
    set_req(1'b1, 1'b1, 32'h0F, 32'h30, 6'h07);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_id = 1'(i % 2);
`else
      exp_id = 1'b0;
`endif
      push(exp_id, exp_id ? 32'h3F : 32'h30, 1'b0, 1'b0);
    end
    #1;
    check("arb_first_ready0", 64'(REQ0_READY), 64'd1);
    check("arb_first_ready1", 64'(REQ1_READY), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      wait_rsp(edges);
      check("arb_spacing", 64'(edges), 64'd2);
      check_rsp("arb");
      if (i == 3) begin
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      end
    end
    expect_idle("arb");

    // Reset during EXEC discards the operation
    set_req(1'b0, 1'b1, 32'd6, 32'd7, 6'h03);
    @(negedge CLK);
    set_req(1'b0, 1'b0, '0, '0, '0);
    check("mid_busy", 64'(BUSY), 64'd1);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_valid", 64'(RSP_VALID), 64'd0);
    check("mid_rst_id",    64'(RSP_ID),    64'd0);
    check("mid_rst_data",  64'(RSP_DATA),  64'd0);
    check("mid_rst_zero",  64'(RSP_ZERO),  64'd0);
    check("mid_rst_err",   64'(RSP_ERR),   64'd0);
    check("mid_rst_busy",  64'(BUSY),      64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("post_rst_no_rsp", 64'(RSP_VALID), 64'd0);
    end

    // First request after reset: requester 0 wins contention
    set_req(1'b0, 1'b1, 32'd100, 32'd23, 6'h01);
    set_req(1'b1, 1'b1, 32'd1, 32'd1, 6'h01);
    push(1'b0, 32'd123, 1'b0, 1'b0);
    #1;
    check("post_rst_ready0", 64'(REQ0_READY), 64'd1);
    check("post_rst_ready1", 64'(REQ1_READY), 64'd0);
    @(negedge CLK);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    wait_rsp(edges);
    check("post_rst_latency", 64'(edges + 1), 64'd2);
    check_rsp("post_rst");
    expect_idle("post_rst");

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL declare parameter DATA_WIDTH, default `DATA_INDEX_LIMIT+1 (32), operand/result width.
REQ-002 SHALL declare parameter OPRN_WIDTH, default `ALU_OPRN_INDEX_LIMIT+1 (6), operation code width.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports REQ0_VALID, REQ1_VALID  input  1 each  requester x has an operation pending.
REQ-006 SHALL have ports REQ0_READY, REQ1_READY  output  1 each  requester x operation accepted this cycle.
REQ-007 SHALL have ports REQ0_OP1, REQ0_OP2, REQ1_OP1, REQ1_OP2  input  DATA_WIDTH each  operands.
REQ-008 SHALL have ports REQ0_OPRN, REQ1_OPRN  input  OPRN_WIDTH each  ALU operation code.
REQ-009 SHALL have ports RSP_VALID (output, 1), RSP_READY (input, 1), RSP_ID (output, 1, requester index), RSP_DATA (output, DATA_WIDTH), RSP_ZERO (output, 1), RSP_ERR (output, 1, illegal code).
REQ-010 SHALL have port BUSY  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL instantiate exactly one ALU and share it between both requesters.
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 SHALL assert REQx_READY combinationally only in IDLE, only for the granted requester, and only while REQx_VALID is high; at most one READY high per cycle.
REQ-014 SHALL treat VALID&READY at a rising edge as accept: latch OP1, OP2, OPRN, ID; IDLE->EXEC.
REQ-015 SHALL in EXEC drive latched operands to the ALU, register OUT into RSP_DATA and ZERO into RSP_ZERO; EXEC->RESP.
REQ-016 SHALL hold RSP_VALID high with stable RSP_ID/DATA/ZERO/ERR throughout RESP; leave RESP->IDLE on the edge where RSP_READY is high.
REQ-017 SHALL give latency: accept at edge n, RSP_VALID high after edge n+1; back-to-back accept no earlier than the edge after the response handshake (minimum 3 cycles per operation).
REQ-018 SHALL treat codes 0x1-0x9 as legal; any other code (0x0, 0xA-0x3F) SHALL produce RSP_DATA=0, RSP_ZERO=1, RSP_ERR=1, with the same latency.
REQ-019 SHALL keep RSP_VALID low and ignore RSP_READY outside RESP.
REQ-020 SHALL never drop or reorder an accepted operation; a requester whose VALID falls before accept is simply not served.

Reset
REQ-021 SHALL on RST low, regardless of clock: state=IDLE, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, RSP_ZERO=0, RSP_ERR=0, BUSY=0, round-robin pointer=1 (requester 0 wins first).
REQ-022 SHALL discard any in-flight operation on reset mid-EXEC or mid-RESP; no response is issued for it.

Configuration
REQ-023 SHALL with ALU_ARB_RR_EN defined use round-robin grant: if both valid, grant the requester not accepted last; pointer updates only on accept.
REQ-024 SHALL without ALU_ARB_RR_EN use fixed priority: requester 0 always wins when both valid; pointer logic absent.

Structure
REQ-025 SHALL take DATA_INDEX_LIMIT, ALU_OPRN_INDEX_LIMIT and new state encodings and legal-code bounds (ALU_ARB_IDLE/EXEC/RESP, ALU_OPRN_MIN=0x1, ALU_OPRN_MAX=0x9) from the shared prj_definition.v.
REQ-026 SHALL place grant logic (valid pair, pointer -> one-hot grant) in one sub-module ALU_ARB_PICK; the ALU is the existing block, unmodified.

Verification
REQ-027 SHALL test: REQ0 only, OP1=5, OP2=3, OPRN=0x1, RSP_READY=1 -> RSP_VALID after 2 edges, RSP_ID=0, RSP_DATA=8, RSP_ZERO=0, RSP_ERR=0.
REQ-028 SHALL test: REQ1 OP1=7, OP2=7, OPRN=0x2 -> RSP_DATA=0, RSP_ZERO=1, RSP_ID=1.
REQ-029 SHALL test: both valid continuously, 4 ops (REQ0 0x6 0xF0&0x3C, REQ1 0x7) -> with ALU_ARB_RR_EN RSP_ID sequence 0,1,0,1; without it 0,0,0,0.
REQ-030 SHALL test: RSP_READY low 5 cycles in RESP -> RSP_VALID/DATA stable, both READY low, BUSY=1; released on edge RSP_READY goes high.
REQ-031 SHALL test: OPRN=0xC, OP1=1, OP2=2 -> RSP_DATA=0, RSP_ZERO=1, RSP_ERR=1.
REQ-032 SHALL test: RST low during EXEC of OPRN=0x3 -> outputs at reset values immediately, no RSP_VALID after release, next request served normally with requester 0 first.
